// File: rtl/perf_counter_sampler_pkg.sv
// -----------------------------------------------------------------------------
// perf_counter_sampler_pkg
// Shared types for the performance-counter sampler:
//   perf_sample_t        - one emitted sample {idx, last, data}
//   perf_sampler_state_e - sweep FSM states
// -----------------------------------------------------------------------------
package perf_counter_sampler_pkg;

    localparam int IDX_W  = 4;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 64;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             last;
        logic [CNT_W-1:0] data;
    } perf_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_PUSH = 2'd2
    } perf_sampler_state_e;

endpackage

// File: rtl/perf_sample_timer.sv
// -----------------------------------------------------------------------------
// perf_sample_timer
// Interval counter producing the periodic sweep trigger.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   period_i        cycles between fires; 0 disables and holds the counter at 0
//   debug_mode_i    freezes the counter and suppresses fires
//   fire_o          registered one-cycle fire pulse
// -----------------------------------------------------------------------------
module perf_sample_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                debug_mode_i,
    output logic                fire_o
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_timer;
    logic                r_fire;
    logic                w_run;
    logic                w_hit;

    assign w_run = (period_i != '0) && !debug_mode_i;
    // ">=" rather than "==" so that lowering period_i below the running
    // count still produces a fire instead of wrapping through 2^PERIOD_W.
    assign w_hit = (r_timer >= (period_i - ONE));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timer <= '0;
            r_fire  <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            if (period_i == '0) begin
                r_timer <= '0;
            end else if (w_run) begin
                if (w_hit) begin
                    r_timer <= '0;
                    r_fire  <= 1'b1;
                end else begin
                    r_timer <= r_timer + ONE;
                end
            end
        end
    end

    assign fire_o = r_fire;

endmodule

// File: rtl/perf_counter_sampler.sv
// -----------------------------------------------------------------------------
// perf_counter_sampler
// Walks counters 0..NR_COUNTERS-1 over the SRAM-like counter port on a manual
// or periodic trigger and streams each value out as a valid/ready sample.
// Optional feature macro: PERF_SAMPLER_CLEAR_EN (clear-on-read via we_o).
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   debug_mode_i                    freeze timer, block new sweeps from idle
//   start_i                         one-cycle manual trigger
//   period_i                        auto-trigger interval (0 = off)
//   req_o/gnt_i                     counter port request / same-cycle grant
//   addr_o/we_o/wdata_o/rdata_i     counter port address/write/data
//   sample_valid_o/sample_ready_i   sample stream handshake
//   sample_o                        {idx, last, data}
//   busy_o                          sweep in progress
//   overrun_o                       sticky lost-trigger flag, cleared by start_i
// -----------------------------------------------------------------------------
module perf_counter_sampler
    import perf_counter_sampler_pkg::*;
#(
    parameter int          NR_COUNTERS = 14,
    parameter logic [11:0] BASE_ADDR   = 12'h000,
    parameter int          PERIOD_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                debug_mode_i,
    input  logic                start_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                req_o,
    input  logic                gnt_i,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                we_o,
    output logic [CNT_W-1:0]    wdata_o,
    input  logic [CNT_W-1:0]    rdata_i,
    output logic                sample_valid_o,
    input  logic                sample_ready_i,
    output perf_sample_t        sample_o,
    output logic                busy_o,
    output logic                overrun_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_COUNTERS - 1);

    perf_sampler_state_e r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_pending;
    logic                r_overrun;
    perf_sample_t        r_sample;

    logic w_fire;
    logic w_trigger;
    logic w_busy;
    logic w_drop;
    logic w_last_acc;

    perf_sample_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .period_i     (period_i),
        .debug_mode_i (debug_mode_i),
        .fire_o       (w_fire)
    );

    // A simultaneous start_i and timer fire collapse into one trigger.
    assign w_trigger  = start_i | w_fire;
    assign w_busy     = (r_state != ST_IDLE);
    // Only one trigger can be queued behind a running sweep.
    assign w_drop     = w_trigger && w_busy && r_pending;
    assign w_last_acc = (r_state == ST_PUSH) && sample_ready_i && (r_idx == LAST_IDX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_sample  <= '0;
        end else begin
            // Set beats clear when start_i itself is the dropped trigger.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (start_i) begin
                r_overrun <= 1'b0;
            end

            // The end of a sweep consumes the queued trigger; otherwise a
            // trigger arriving mid-sweep is queued.
            if (w_last_acc) begin
                r_pending <= 1'b0;
            end else if (w_busy && w_trigger && !r_pending) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_trigger && !debug_mode_i) begin
                        r_idx   <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (gnt_i) begin
                        r_sample.idx  <= r_idx;
                        r_sample.last <= (r_idx == LAST_IDX);
                        r_sample.data <= rdata_i;
                        r_state       <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (sample_ready_i) begin
                        if (r_idx != LAST_IDX) begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= ST_READ;
                        end else begin
                            r_idx <= '0;
                            // A trigger landing on the final handshake
                            // restarts directly rather than being stranded
                            // as pending in IDLE.
                            if (r_pending || w_trigger) begin
                                r_state <= ST_READ;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_o          = (r_state == ST_READ);
    assign addr_o         = BASE_ADDR + {{(ADDR_W-IDX_W){1'b0}}, r_idx};
    assign wdata_o        = '0;
    assign sample_valid_o = (r_state == ST_PUSH);
    assign sample_o       = r_sample;
    assign busy_o         = w_busy;
    assign overrun_o      = r_overrun;

`ifdef PERF_SAMPLER_CLEAR_EN
    // Granted read doubles as a zeroing write: old value returned, counter cleared.
    assign we_o = req_o;
`else
    assign we_o = 1'b0;
`endif

endmodule
